ddr_score_bcd: RTL and testbench
================================

Name: ddr_score_bcd

Overview:
- Game score and combo accumulator for the dance game. Consumes one-cycle judgement pulses from the step-judging logic.
- Keeps a 4-digit BCD score, a 2-digit BCD current combo and a 2-digit BCD best combo.
- Every digit output is a 4-bit BCD value (0-9) that drives one seven-segment decoder instance directly, so no binary-to-BCD conversion is needed downstream.

Parameters:
- PTS_PERFECT, 3, BCD points added per perfect hit (1-9).
- PTS_GOOD, 1, BCD points added per good hit (1-9).
- BONUS_COMBO, 10, combo value at or above which each hit earns +1 bonus point (1-99).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous game-restart. Zeroes score and current combo; keeps best combo.
- active  input  1  judgement pulses are accepted only while high.
- hit_perfect  input  1  one-cycle pulse, perfect step.
- hit_good  input  1  one-cycle pulse, good step.
- miss  input  1  one-cycle pulse, missed step.
- score_d3, score_d2, score_d1, score_d0  output  4 each  score BCD digits, thousands..units.
- combo_d1, combo_d0  output  4 each  current combo BCD digits.
- best_d1, best_d0  output  4 each  best combo BCD digits.
- score_sat  output  1  high once score has saturated at 9999.

Behaviour:
- One clock domain; reset_n is asynchronous and active-low. All state is registered on the rising edge of clk.
- Reset values: all digit outputs 0, score_sat 0.
- Event decode, only when active=1:
  - Priority: miss > hit_perfect > hit_good.
  - At most one event is taken per cycle; lower-priority pulses in the same cycle are dropped.
  - When active=0, all pulses are ignored.
- clear:
  - Overrides any event in the same cycle.
  - Sets score digits to 0, combo digits to 0 and score_sat to 0.
  - Leaves best combo unchanged.
- Latency: outputs reflect an event on the cycle after the pulse (1-cycle registered latency).
- Miss:
  - Combo becomes 00.
  - Score and best are unchanged.
- Hit (perfect or good):
  - Base points are PTS_PERFECT or PTS_GOOD.
  - Add +1 bonus if the combo before this hit is >= BONUS_COMBO, compared as a 2-digit BCD value.
  - The addend (max 10) is added to the score with per-digit decimal-carry ripple: digit sum > 9 means subtract 10 and carry 1.
- Score saturation:
  - If the sum would exceed 9999, the score is set to 9999 and score_sat goes high.
  - score_sat stays high until clear or reset.
  - While saturated, further hits leave the score at 9999 but still update combo and best.
- Combo increment:
  - BCD increment with saturation at 99; at 99 a hit leaves combo at 99.
  - Units 9 rolls to 0 with a carry into tens.
- Best combo:
  - If the new combo value exceeds best, best takes the new value in the same cycle as the combo update.
  - Best is therefore never less than combo after any cycle.
- Every digit register holds only 0-9 under all input sequences.
- Reset mid-game: asserting reset_n low clears everything, including best, immediately and independent of clk.

Test Plan:
- Reset, then 3 hit_perfect pulses with active=1 -> score 0009, combo 03, best 03, each update one cycle after its pulse.
- Combo driven to 10, then one hit_perfect -> bonus applies, score +4, combo 11; a following hit_good adds 2.
- Preload score to 9998 via hits, then hit_perfect -> score 9999, score_sat=1. A further hit_good -> score 9999, combo still increments.
- Combo 15, miss, then 2 hit_good -> combo 02, best 15. Then clear -> score 0000, combo 00, best 15, score_sat 0.
- Same-cycle pulses:
  - miss+hit_perfect -> only the miss is taken: combo 00, score unchanged.
  - hit_perfect+hit_good -> only +PTS_PERFECT is added.
  - With active=0, any pulse -> no change.
- Combo at 99, hit_good -> combo 99, best 99.
- Async reset asserted mid-cycle -> all outputs 0 before the next clk edge.
- All cases: check every digit stays <= 9 throughout.

Source files
------------

// File: rtl/ddr_score_bcd.sv
// ddr_score_bcd: dance-game score and combo accumulator.
// Keeps a 4-digit BCD score, a 2-digit BCD current combo and a 2-digit BCD
// best combo. Every digit is held as BCD so it can feed a seven-segment
// decoder directly. One judgement is taken per cycle: miss > perfect > good.
module ddr_score_bcd #(
  parameter int PTS_PERFECT = 3,
  parameter int PTS_GOOD    = 1,
  parameter int BONUS_COMBO = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       active,
  input  logic       hit_perfect,
  input  logic       hit_good,
  input  logic       miss,
  output logic [3:0] score_d3,
  output logic [3:0] score_d2,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [3:0] combo_d1,
  output logic [3:0] combo_d0,
  output logic [3:0] best_d1,
  output logic [3:0] best_d0,
  output logic       score_sat
);

  localparam logic [3:0] PERFECT_PTS = 4'(PTS_PERFECT);
  localparam logic [3:0] GOOD_PTS    = 4'(PTS_GOOD);
  localparam logic [3:0] BONUS_TENS  = 4'(BONUS_COMBO / 10);
  localparam logic [3:0] BONUS_UNITS = 4'(BONUS_COMBO % 10);

  // One BCD digit add: returns {carry_out, digit}. The inputs never push the
  // raw sum above 19, so a single subtract-10 keeps the digit in 0-9.
  function automatic logic [4:0] bcd_add(input logic [3:0] d,
                                         input logic [3:0] a,
                                         input logic       cin);
    logic [4:0] s;
    logic       c;
    s = {1'b0, d} + {1'b0, a} + {4'b0, cin};
    c = 1'b0;
    if (s > 5'd9) begin
      s = s - 5'd10;
      c = 1'b1;
    end
    return {c, s[3:0]};
  endfunction

  logic       take_miss;
  logic       take_hit;
  logic       bonus;
  logic [3:0] addend;
  logic [4:0] sum0, sum1, sum2, sum3;
  logic       combo_at_max;
  logic [3:0] n_s3, n_s2, n_s1, n_s0;
  logic [3:0] n_c1, n_c0, n_b1, n_b0;
  logic       n_sat;

  // Decode the judgement, form the addend and compute every next-state digit.
  always_comb begin
    take_miss    = active & miss;
    take_hit     = active & ~miss & (hit_perfect | hit_good);
    bonus        = (combo_d1 > BONUS_TENS) ||
                   ((combo_d1 == BONUS_TENS) && (combo_d0 >= BONUS_UNITS));
    addend       = (hit_perfect ? PERFECT_PTS : GOOD_PTS) + {3'b0, bonus};
    sum0         = bcd_add(score_d0, addend, 1'b0);
    sum1         = bcd_add(score_d1, 4'd0, sum0[4]);
    sum2         = bcd_add(score_d2, 4'd0, sum1[4]);
    sum3         = bcd_add(score_d3, 4'd0, sum2[4]);
    combo_at_max = (combo_d1 == 4'd9) && (combo_d0 == 4'd9);

    n_s3  = score_d3;
    n_s2  = score_d2;
    n_s1  = score_d1;
    n_s0  = score_d0;
    n_c1  = combo_d1;
    n_c0  = combo_d0;
    n_sat = score_sat;

    if (clear) begin
      n_s3  = 4'd0;
      n_s2  = 4'd0;
      n_s1  = 4'd0;
      n_s0  = 4'd0;
      n_c1  = 4'd0;
      n_c0  = 4'd0;
      n_sat = 1'b0;
    end else if (take_miss) begin
      n_c1 = 4'd0;
      n_c0 = 4'd0;
    end else if (take_hit) begin
      // Once saturated the score is pinned; otherwise a thousands carry-out
      // means the sum passed 9999.
      if (score_sat || sum3[4]) begin
        n_s3  = 4'd9;
        n_s2  = 4'd9;
        n_s1  = 4'd9;
        n_s0  = 4'd9;
        n_sat = 1'b1;
      end else begin
        n_s3 = sum3[3:0];
        n_s2 = sum2[3:0];
        n_s1 = sum1[3:0];
        n_s0 = sum0[3:0];
      end
      if (!combo_at_max) begin
        if (combo_d0 == 4'd9) begin
          n_c1 = combo_d1 + 4'd1;
          n_c0 = 4'd0;
        end else begin
          n_c0 = combo_d0 + 4'd1;
        end
      end
    end

    // Best follows the new combo in the same cycle whenever it is exceeded.
    n_b1 = best_d1;
    n_b0 = best_d0;
    if ((n_c1 > best_d1) || ((n_c1 == best_d1) && (n_c0 > best_d0))) begin
      n_b1 = n_c1;
      n_b0 = n_c0;
    end
  end

  // Register all digits and the saturation flag; reset clears best too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_d3  <= 4'd0;
      score_d2  <= 4'd0;
      score_d1  <= 4'd0;
      score_d0  <= 4'd0;
      combo_d1  <= 4'd0;
      combo_d0  <= 4'd0;
      best_d1   <= 4'd0;
      best_d0   <= 4'd0;
      score_sat <= 1'b0;
    end else begin
      score_d3  <= n_s3;
      score_d2  <= n_s2;
      score_d1  <= n_s1;
      score_d0  <= n_s0;
      combo_d1  <= n_c1;
      combo_d0  <= n_c0;
      best_d1   <= n_b1;
      best_d0   <= n_b0;
      score_sat <= n_sat;
    end
  end

endmodule

// File: tb/tb_ddr_score_bcd.sv
// Testbench for ddr_score_bcd: directed game scenarios plus random pulses,
// checked against an integer model of the scoring rules.
module tb_ddr_score_bcd;

  localparam int PP = 3;
  localparam int PG = 1;
  localparam int BC = 10;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       active;
  logic       hit_perfect;
  logic       hit_good;
  logic       miss;
  logic [3:0] score_d3, score_d2, score_d1, score_d0;
  logic [3:0] combo_d1, combo_d0, best_d1, best_d0;
  logic       score_sat;

  int n_checks;
  int n_fail;

  // Reference model state (plain integers).
  int m_score;
  int m_combo;
  int m_best;
  int m_sat;

  ddr_score_bcd #(
    .PTS_PERFECT(PP),
    .PTS_GOOD(PG),
    .BONUS_COMBO(BC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clear(clear),
    .active(active),
    .hit_perfect(hit_perfect),
    .hit_good(hit_good),
    .miss(miss),
    .score_d3(score_d3),
    .score_d2(score_d2),
    .score_d1(score_d1),
    .score_d0(score_d0),
    .combo_d1(combo_d1),
    .combo_d0(combo_d0),
    .best_d1(best_d1),
    .best_d0(best_d0),
    .score_sat(score_sat)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dut_score();
    return int'(score_d3) * 1000 + int'(score_d2) * 100 + int'(score_d1) * 10 + int'(score_d0);
  endfunction

  function automatic int dut_combo();
    return int'(combo_d1) * 10 + int'(combo_d0);
  endfunction

  function automatic int dut_best();
    return int'(best_d1) * 10 + int'(best_d0);
  endfunction

  function automatic int digits_ok();
    return (score_d3 <= 9 && score_d2 <= 9 && score_d1 <= 9 && score_d0 <= 9 &&
            combo_d1 <= 9 && combo_d0 <= 9 && best_d1 <= 9 && best_d0 <= 9) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_score"}, dut_score(), m_score);
    check({tag, "_combo"}, dut_combo(), m_combo);
    check({tag, "_best"}, dut_best(), m_best);
    check({tag, "_sat"}, int'(score_sat), m_sat);
    check({tag, "_digits"}, digits_ok(), 1);
  endtask

  // Scoreboard model: game rules in integer arithmetic.
  task automatic model_step(input bit c, input bit a, input bit hp, input bit hg, input bit ms);
    int add;
    if (c) begin
      m_score = 0;
      m_combo = 0;
      m_sat   = 0;
    end else if (a) begin
      if (ms) begin
        m_combo = 0;
      end else if (hp || hg) begin
        add = (hp ? PP : PG) + ((m_combo >= BC) ? 1 : 0);
        if (m_score + add > 9999) begin
          m_score = 9999;
          m_sat   = 1;
        end else begin
          m_score = m_score + add;
        end
        m_combo = (m_combo < 99) ? m_combo + 1 : 99;
        if (m_combo > m_best) m_best = m_combo;
      end
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, check after the edge.
  task automatic step(input string tag, input bit c, input bit a,
                      input bit hp, input bit hg, input bit ms);
    @(negedge clk);
    clear       = c;
    active      = a;
    hit_perfect = hp;
    hit_good    = hg;
    miss        = ms;
    @(posedge clk);
    model_step(c, a, hp, hg, ms);
    #1;
    clear       = 1'b0;
    hit_perfect = 1'b0;
    hit_good    = 1'b0;
    miss        = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_score = 0;
    m_combo = 0;
    m_best  = 0;
    m_sat   = 0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    clear       = 1'b0;
    active      = 1'b0;
    hit_perfect = 1'b0;
    hit_good    = 1'b0;
    miss        = 1'b0;
    reset_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Three perfects: 0009 / 03 / 03, each visible one cycle after its pulse.
    for (int i = 0; i < 3; i++) step("perfect3", 0, 1, 1, 0, 0);
    check("perfect3_total", dut_score(), 9);

    // Drive combo to 10, then bonus perfect (+4) and bonus good (+2).
    for (int i = 0; i < 7; i++) step("to_combo10", 0, 1, 1, 0, 0);
    step("bonus_perfect", 0, 1, 1, 0, 0);
    step("bonus_good", 0, 1, 0, 1, 0);

    // Combo to 15, miss, two goods, then clear keeps best.
    step("miss_reset", 0, 1, 0, 0, 1);
    for (int i = 0; i < 15; i++) step("to_combo15", 0, 1, 0, 1, 0);
    step("miss15", 0, 1, 0, 0, 1);
    step("good_a", 0, 1, 0, 1, 0);
    step("good_b", 0, 1, 0, 1, 0);
    check("best15", dut_best(), 15);
    step("clear", 1, 1, 1, 0, 0);

    // Same-cycle pulses and inactive pulses.
    step("pre_same", 0, 1, 1, 0, 0);
    step("miss_and_perfect", 0, 1, 1, 0, 1);
    step("perfect_and_good", 0, 1, 1, 1, 0);
    step("all_three", 0, 1, 1, 1, 1);
    step("inactive_perfect", 0, 0, 1, 0, 0);
    step("inactive_miss", 0, 0, 0, 0, 1);
    step("inactive_all", 0, 0, 1, 1, 1);

    // Combo saturation at 99.
    for (int i = 0; i < 101; i++) step("combo99", 0, 1, 0, 1, 0);
    check("combo_sat99", dut_combo(), 99);

    // Build the score up to exactly 9998, then saturate.
    while (m_score < 9990) step("climb", 0, 1, 1, 0, 0);
    while (m_score < 9998) begin
      if (m_combo >= 9) step("fine_miss", 0, 1, 0, 0, 1);
      else step("fine_good", 0, 1, 0, 1, 0);
    end
    check("at9998", dut_score(), 9998);
    step("saturate", 0, 1, 1, 0, 0);
    check("sat_flag", int'(score_sat), 1);
    step("sat_hold", 0, 1, 0, 1, 0);
    step("sat_clear", 1, 0, 0, 0, 0);

    // Random pulses with occasional clear.
    for (int i = 0; i < 1500; i++) begin
      step("random", ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0));
    end

    // Async reset mid-cycle: outputs must clear before the next edge.
    for (int i = 0; i < 5; i++) step("pre_async", 0, 1, 1, 0, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step("post_reset", 0, 1, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
